// File: rtl/wb4_to_pi1.sv
// wb4_to_pi1: Wishbone B4 pipelined slave replaying requests as PI1 master ops.
// Ports: clk_i/rst_i; wb4_* slave side (cyc/stb/we/addr/data/sel in,
//   stall/ack/data out); pi1_* master side (op/addr/data/sel out,
//   data/rdy in). One PI1 op in flight, acks in enqueue order.
module wb4_to_pi1 #(
  parameter int ARCHBITSZ = 32,
  parameter int BUFSZ     = 2
) (
  input  logic                                       clk_i,
  input  logic                                       rst_i,
  input  logic                                       wb4_cyc_i,
  input  logic                                       wb4_stb_i,
  input  logic                                       wb4_we_i,
  input  logic [ARCHBITSZ-1:0]                       wb4_addr_i,
  input  logic [ARCHBITSZ-1:0]                       wb4_data_i,
  input  logic [ARCHBITSZ/8-1:0]                     wb4_sel_i,
  output logic                                       wb4_stall_o,
  output logic                                       wb4_ack_o,
  output logic [ARCHBITSZ-1:0]                       wb4_data_o,
  output logic [1:0]                                 pi1_op_o,
  output logic [ARCHBITSZ-$clog2(ARCHBITSZ/8)-1:0]   pi1_addr_o,
  output logic [ARCHBITSZ-1:0]                       pi1_data_o,
  input  logic [ARCHBITSZ-1:0]                       pi1_data_i,
  output logic [ARCHBITSZ/8-1:0]                     pi1_sel_o,
  input  logic                                       pi1_rdy_i
);

  localparam int SELW = ARCHBITSZ / 8;
  localparam int OFFW = $clog2(SELW);
  localparam int AW   = ARCHBITSZ - OFFW;
  localparam int PW   = $clog2(BUFSZ);
  localparam int CW   = PW + 1;

  localparam logic [1:0] PINOOP = 2'd0;
  localparam logic [1:0] PIWROP = 2'd1;
  localparam logic [1:0] PIRDOP = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_RDWAIT
  } state_t;

  state_t r_state;
  state_t w_state_nx;

  logic                 r_fwe   [BUFSZ];
  logic [AW-1:0]        r_faddr [BUFSZ];
  logic [ARCHBITSZ-1:0] r_fdata [BUFSZ];
  logic [SELW-1:0]      r_fsel  [BUFSZ];

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;
  logic          r_abort;

  logic [1:0]           r_op;
  logic [AW-1:0]        r_paddr;
  logic [ARCHBITSZ-1:0] r_pdata;
  logic [SELW-1:0]      r_psel;
  logic                 r_ack;
  logic [ARCHBITSZ-1:0] r_rdata;

  logic w_empty;
  logic w_full;
  logic w_busy;
  logic w_abort;
  logic w_push;
  logic w_pop;
  logic w_load;
  logic w_accept;
  logic w_rdone;
  logic w_ack_ok;
  logic w_unused_addr;

  // Byte-offset bits never reach PI1.
  assign w_unused_addr = ^wb4_addr_i[OFFW-1:0];

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CW'(BUFSZ));
  assign w_busy  = !w_empty || (r_state != S_IDLE);

  // Dropping cyc with work pending cancels everything not yet on PI1.
  assign w_abort = !wb4_cyc_i && w_busy;

  assign wb4_stall_o = rst_i | w_full | r_abort;
  assign w_push = wb4_cyc_i & wb4_stb_i & !wb4_stall_o;

  // A flush already discarded the head slot, so do not pop it twice.
  assign w_pop    = w_accept & !w_empty & !w_abort;
  assign w_ack_ok = !(r_abort | w_abort);

  always_comb begin
    w_state_nx = r_state;
    w_load     = 1'b0;
    w_accept   = 1'b0;
    w_rdone    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!w_empty && !w_abort) begin
          w_load     = 1'b1;
          w_state_nx = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (pi1_rdy_i) begin
          w_accept   = 1'b1;
          w_state_nx = (r_op == PIWROP) ? S_IDLE : S_RDWAIT;
        end
      end
      S_RDWAIT: begin
        if (pi1_rdy_i) begin
          w_rdone    = 1'b1;
          w_state_nx = S_IDLE;
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (w_abort) begin
      r_rptr <= r_wptr;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fwe[r_wptr]   <= wb4_we_i;
      r_faddr[r_wptr] <= wb4_addr_i[ARCHBITSZ-1:OFFW];
      r_fdata[r_wptr] <= wb4_data_i;
      r_fsel[r_wptr]  <= wb4_sel_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_abort <= 1'b0;
    end else if (w_abort) begin
      r_abort <= 1'b1;
    end else if (r_state == S_IDLE) begin
      r_abort <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_op    <= PINOOP;
      r_paddr <= '0;
      r_pdata <= '0;
      r_psel  <= '0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= 1'b0;
      if (w_load) begin
        r_op    <= r_fwe[r_rptr] ? PIWROP : PIRDOP;
        r_paddr <= r_faddr[r_rptr];
        r_pdata <= r_fdata[r_rptr];
        r_psel  <= r_fsel[r_rptr];
      end
      if (w_accept) begin
        r_op <= PINOOP;
        if (r_op == PIWROP) begin
          r_ack <= w_ack_ok;
        end
      end
      if (w_rdone) begin
        r_rdata <= pi1_data_i;
        r_ack   <= w_ack_ok;
      end
    end
  end

  assign pi1_op_o   = r_op;
  assign pi1_addr_o = r_paddr;
  assign pi1_data_o = r_pdata;
  assign pi1_sel_o  = r_psel;
  assign wb4_ack_o  = r_ack;
  assign wb4_data_o = r_rdata;

endmodule

// File: tb/tb_wb4_to_pi1.sv
// tb_wb4_to_pi1: vector table, corner sequences and a randomized
// queue-based reference model for wb4_to_pi1.
module tb_wb4_to_pi1;

  localparam int AB = 32;
  localparam int BS = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  sel;
  logic        stall;
  logic        ack;
  logic [31:0] dout;
  logic [1:0]  op;
  logic [29:0] paddr;
  logic [31:0] pdata;
  logic [31:0] pdin;
  logic [3:0]  psel;
  logic        rdy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb4_to_pi1 #(.ARCHBITSZ(AB), .BUFSZ(BS)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .wb4_cyc_i  (cyc),
    .wb4_stb_i  (stb),
    .wb4_we_i   (we),
    .wb4_addr_i (addr),
    .wb4_data_i (wdata),
    .wb4_sel_i  (sel),
    .wb4_stall_o(stall),
    .wb4_ack_o  (ack),
    .wb4_data_o (dout),
    .pi1_op_o   (op),
    .pi1_addr_o (paddr),
    .pi1_data_o (pdata),
    .pi1_data_i (pdin),
    .pi1_sel_o  (psel),
    .pi1_rdy_i  (rdy)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          wait_n;
    int          gap_n;
    logic [31:0] rdata;
    logic [1:0]  exp_op;
    logic [29:0] exp_paddr;
    int          exp_lat;
    logic [31:0] exp_dout;
  } vec_t;

  vec_t tbl[6];

  typedef struct {
    logic        we;
    logic [29:0] a;
    logic [31:0] d;
    logic [3:0]  s;
  } req_t;

  typedef struct {
    logic        we;
    logic [31:0] d;
  } ackr_t;

  req_t  q_req[$];
  ackr_t q_ack[$];
  logic  rd_pend;
  int    tot_enq;
  int    tot_ack;

  // One cycle of the reference model: outputs are compared mid-cycle,
  // then the events of the coming edge update the queues.
  task automatic step_model();
    logic  exp_stall;
    req_t  r;
    ackr_t a;
    @(negedge clk);
    exp_stall = (q_req.size() >= BS);
    chk("rnd_stall", stall, exp_stall);
    if (q_ack.size() > 0) begin
      a = q_ack.pop_front();
      tot_ack++;
      chk("rnd_ack", ack, 1);
      if (!a.we) chk("rnd_rdata", dout, a.d);
    end else begin
      chk("rnd_noack", ack, 0);
    end
    if (rd_pend && rdy) begin
      a.we = 1'b0;
      a.d  = pdin;
      q_ack.push_back(a);
      rd_pend = 1'b0;
    end else if (op != 2'd0 && rdy) begin
      if (q_req.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rnd_phantom actual=op%0d required=none", op);
      end else begin
        r = q_req.pop_front();
        chk("rnd_op", op, r.we ? 2'd1 : 2'd2);
        chk("rnd_paddr", paddr, r.a);
        chk("rnd_psel", psel, r.s);
        if (r.we) begin
          chk("rnd_pdata", pdata, r.d);
          a.we = 1'b1;
          a.d  = '0;
          q_ack.push_back(a);
        end else begin
          rd_pend = 1'b1;
        end
      end
    end
    if (cyc && stb && !exp_stall) begin
      r.we = we;
      r.a  = addr[31:2];
      r.d  = wdata;
      r.s  = sel;
      q_req.push_back(r);
      tot_enq++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int first;
  int acks;
  int accepts;
  int n_sent;
  int first_stall;
  logic sent_now;
  logic [29:0] acc_a[$];
  logic [29:0] tmp_a;

  initial begin
    tbl[0] = '{1'b1, 32'h0000_1004, 32'hDEAD_BEEF, 4'hF, 0, 0,
               32'h0, 2'd1, 30'h401, 2, 32'h0};
    tbl[1] = '{1'b0, 32'h0000_2000, 32'h0, 4'hF, 0, 1,
               32'h1234_5678, 2'd2, 30'h800, 4, 32'h1234_5678};
    tbl[2] = '{1'b0, 32'h0000_3008, 32'h0, 4'h3, 0, 0,
               32'hA5A5_0F0F, 2'd2, 30'hC02, 3, 32'hA5A5_0F0F};
    tbl[3] = '{1'b1, 32'hFFFF_FFFC, 32'h0, 4'h8, 10, 0,
               32'h0, 2'd1, 30'h3FFF_FFFF, 12, 32'hA5A5_0F0F};
    tbl[4] = '{1'b1, 32'h0000_0003, 32'h1122_3344, 4'h1, 1, 0,
               32'h0, 2'd1, 30'h0, 3, 32'hA5A5_0F0F};
    tbl[5] = '{1'b0, 32'h0000_7FFC, 32'h0, 4'hF, 2, 3,
               32'hFFFF_FFFF, 2'd2, 30'h1FFF, 8, 32'hFFFF_FFFF};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    addr = '0; wdata = '0; sel = '0; pdin = '0; rdy = 1'b0;
    #1;
    chk("rst_stall", stall, 1);
    tick();
    tick();
    chk("rst_op", op, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pdata", pdata, 0);
    chk("rst_psel", psel, 0);
    chk("rst_ack", ack, 0);
    chk("rst_dout", dout, 0);
    chk("rst_stall_held", stall, 1);
    rst = 1'b0;
    tick();
    chk("post_rst_stall", stall, 0);

    for (int v = 0; v < 6; v++) begin
      cyc = 1'b1; stb = 1'b1; we = tbl[v].we;
      addr = tbl[v].addr; wdata = tbl[v].wdata; sel = tbl[v].sel;
      pdin = tbl[v].rdata; rdy = 1'b1;
      #1;
      chk("vec_stall_in", stall, 0);
      tick();
      stb = 1'b0;
      first = -1; acks = 0; accepts = 0;
      for (int k = 1; k <= tbl[v].exp_lat + 3; k++) begin
        rdy = !(k >= 2 && k < 2 + tbl[v].wait_n) &&
              !(!tbl[v].we && k >= 3 + tbl[v].wait_n &&
                k < 3 + tbl[v].wait_n + tbl[v].gap_n);
        #1;
        if (op != 2'd0 && rdy) accepts++;
        tick();
        chk("vec_stall", stall, 0);
        if (k == 1) begin
          chk("vec_op", op, tbl[v].exp_op);
          chk("vec_paddr", paddr, tbl[v].exp_paddr);
          chk("vec_psel", psel, tbl[v].sel);
          if (tbl[v].we) chk("vec_pdata", pdata, tbl[v].wdata);
        end
        if (k > 1 && k < 2 + tbl[v].wait_n) begin
          chk("bp_op", op, tbl[v].exp_op);
          chk("bp_paddr", paddr, tbl[v].exp_paddr);
          chk("bp_pdata", pdata, tbl[v].wdata);
          chk("bp_psel", psel, tbl[v].sel);
        end
        if (ack) begin
          acks++;
          if (first < 0) first = k;
          chk("vec_dout", dout, tbl[v].exp_dout);
        end
      end
      chk("vec_lat", first, tbl[v].exp_lat);
      chk("vec_acks", acks, 1);
      chk("vec_accepts", accepts, 1);
    end

    // Pipelined burst of four writes, slave always ready.
    cyc = 1'b1; rdy = 1'b1; n_sent = 0; first_stall = -1; acks = 0;
    acc_a.delete();
    for (int c = 0; c < 30; c++) begin
      if (n_sent < 4) begin
        stb = 1'b1; we = 1'b1;
        addr = 32'h100 + 32'(n_sent) * 4;
        wdata = 32'hC0DE_0000 + 32'(n_sent);
        sel = 4'hF;
      end else begin
        stb = 1'b0;
      end
      #1;
      if (stb && stall && first_stall < 0) first_stall = n_sent;
      if (op != 2'd0 && rdy) acc_a.push_back(paddr);
      sent_now = stb && !stall;
      tick();
      if (sent_now) n_sent++;
      if (ack) acks++;
    end
    chk("burst_stall_at", first_stall, 2);
    chk("burst_acks", acks, 4);
    chk("burst_accepts", acc_a.size(), 4);
    for (int i = 0; i < 4; i++) begin
      tmp_a = (i < acc_a.size()) ? acc_a[i] : '1;
      chk("burst_order", tmp_a, 30'h40 + 30'(i));
    end

    // Abort with the first of two reads waiting for data.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h500; sel = 4'hF;
    rdy = 1'b1; pdin = 32'h5555_AAAA;
    tick();
    addr = 32'h504;
    tick();
    chk("abort_op", op, 2);
    chk("abort_paddr", paddr, 30'h140);
    stb = 1'b0;
    tick();
    rdy = 1'b0; cyc = 1'b0;
    tick();
    chk("abort_stall", stall, 1);
    rdy = 1'b1; stb = 1'b1;
    acks = 0; accepts = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (op != 2'd0 && rdy) accepts++;
      tick();
      if (ack) acks++;
    end
    chk("abort_acks", acks, 0);
    chk("abort_accepts", accepts, 0);
    chk("abort_op_idle", op, 0);
    chk("abort_stall_clr", stall, 0);

    // Reset while a read waits for its data.
    cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = 32'h600; rdy = 1'b1;
    tick();
    stb = 1'b0;
    tick();
    tick();
    rdy = 1'b0; rst = 1'b1;
    #1;
    chk("mrst_stall", stall, 1);
    tick();
    chk("mrst_op", op, 0);
    chk("mrst_ack", ack, 0);
    rdy = 1'b1;
    tick();
    chk("mrst_ack2", ack, 0);
    rst = 1'b0;
    acks = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ack || op != 2'd0) acks++;
    end
    chk("mrst_quiet", acks, 0);
    chk("mrst_stall_rel", stall, 0);
    stb = 1'b1; we = 1'b1; addr = 32'h700; wdata = 32'h0BAD_F00D;
    tick();
    stb = 1'b0;
    tick();
    chk("mrst_wop", op, 1);
    chk("mrst_waddr", paddr, 30'h1C0);
    tick();
    chk("mrst_wack", ack, 1);
    tick();
    chk("mrst_wack_end", ack, 0);

    // Randomized traffic against the queue model.
    q_req.delete(); q_ack.delete(); rd_pend = 1'b0;
    tot_enq = 0; tot_ack = 0;
    cyc = 1'b1;
    for (int i = 0; i < 500; i++) begin
      stb   = ($urandom_range(0, 2) != 0);
      we    = 1'($urandom);
      addr  = $urandom;
      wdata = $urandom;
      sel   = 4'($urandom);
      rdy   = ($urandom_range(0, 3) != 0);
      pdin  = $urandom;
      step_model();
    end
    stb = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (q_req.size() == 0 && q_ack.size() == 0 && !rd_pend) break;
      rdy  = ($urandom_range(0, 1) != 0);
      pdin = $urandom;
      step_model();
    end
    chk("drain_req", q_req.size(), 0);
    chk("drain_ack", q_ack.size(), 0);
    chk("drain_rd", rd_pend, 0);
    chk("rnd_count", tot_ack, tot_enq);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
